// File: rtl/viterbi_pkg.sv
// Shared definitions for the 4-state (K=3) Viterbi decoder: the trellis
// state type, the traceback FSM encoding and the predecessor-state helper
// used by both the ACS array and the traceback unit.
package viterbi_pkg;

    localparam int NUM_STATES = 4;
    localparam int STATE_W    = 2;

    // s = {s1, s0}; s1 is the newest input bit.
    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic [1:0] {
        TB_FILL  = 2'd0,
        TB_TRACE = 2'd1,
        TB_EMIT  = 2'd2
    } tb_fsm_t;

    // Predecessor of state s, given the survivor decision bit d of s.
    function automatic state_t pred_state(state_t s, logic d);
        return {s[0], d};
    endfunction

endpackage

// File: rtl/viterbi_traceback_survivor_sel.sv
// survivor_sel: 4:1 combinational select of one survivor decision bit.
// Ports:
//   dec   in  4  decision word, bit s belongs to state s
//   state in  2  state whose decision is wanted
//   sel   out 1  dec[state]
module survivor_sel
    import viterbi_pkg::*;
(
    input  logic [NUM_STATES-1:0] dec,
    input  state_t                state,
    output logic                  sel
);

    assign sel = dec[state];

endmodule

// File: rtl/viterbi_traceback.sv
// viterbi_traceback: block traceback unit for the 4-state Viterbi decoder.
// Collects FRAME_LEN survivor-decision words, traces back from the best
// final state one step per cycle, then streams the decoded bits out in
// forward (time) order.
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   in_valid/in_ready    decision-word handshake (in_ready high only in FILL)
//   in_dec[3:0]          survivor decision per state
//   in_best[1:0]         best final state, used only on the last beat
//   out_valid/out_ready  decoded-bit handshake
//   out_bit, out_last    decoded bit, last-bit-of-frame marker
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. valid never depends on ready; once out_valid is high, out_bit
// and out_last hold until the transfer. All outputs decode registered state
// only, so there is no input-to-output combinational path.
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_STATES-1:0] in_dec,
    input  state_t                in_best,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit,
    output logic                  out_last
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    tb_fsm_t state, state_nxt;

    logic [CNT_W-1:0]      wr_idx;
    logic [CNT_W-1:0]      tb_idx;
    logic [CNT_W-1:0]      rd_idx;
    state_t                cur_state;

    logic [NUM_STATES-1:0] dec_mem [FRAME_LEN];
    logic                  bit_mem [FRAME_LEN];

    logic in_beat;
    logic out_xfer;
    logic sel_bit;

    assign in_ready  = (state == TB_FILL);
    assign out_valid = (state == TB_EMIT);
    // Gated so the unreset bit memory never leaks onto out_bit outside EMIT.
    assign out_bit   = out_valid & bit_mem[rd_idx];
    assign out_last  = out_valid && (rd_idx == LAST_IDX);

    assign in_beat  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    survivor_sel u_sel (
        .dec   (dec_mem[tb_idx]),
        .state (cur_state),
        .sel   (sel_bit)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= TB_FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TB_FILL:  if (in_beat && (wr_idx == LAST_IDX)) state_nxt = TB_TRACE;
            TB_TRACE: if (tb_idx == '0)                    state_nxt = TB_EMIT;
            TB_EMIT:  if (out_xfer && out_last)            state_nxt = TB_FILL;
            default:  state_nxt = TB_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and traceback state. Each index is reloaded explicitly
    // when its phase ends, so none ever wraps past FRAME_LEN-1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx    <= '0;
            tb_idx    <= '0;
            rd_idx    <= '0;
            cur_state <= '0;
        end else begin
            case (state)
                TB_FILL: begin
                    if (in_beat) begin
                        if (wr_idx == LAST_IDX) begin
                            wr_idx    <= '0;
                            tb_idx    <= LAST_IDX;
                            cur_state <= in_best;
                        end else begin
                            wr_idx <= wr_idx + ONE;
                        end
                    end
                end
                TB_TRACE: begin
                    cur_state <= pred_state(cur_state, sel_bit);
                    if (tb_idx == '0) rd_idx <= '0;
                    else              tb_idx <= tb_idx - ONE;
                end
                TB_EMIT: begin
                    if (out_xfer) begin
                        if (rd_idx == LAST_IDX) rd_idx <= '0;
                        else                    rd_idx <= rd_idx + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Survivor and decoded-bit memories (not reset).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && (state == TB_FILL) && in_beat)
            dec_mem[wr_idx] <= in_dec;
        // The decoded bit at step t is the newest input bit of the state
        // occupied at step t.
        if (rst_n && (state == TB_TRACE))
            bit_mem[tb_idx] <= cur_state[1];
    end

endmodule
